// File: rtl/gpio_bus_arb.sv
// Two-requester round-robin arbiter in front of a single GPIO register port.
// Define GPIO_BUS_ARB_TIMEOUT_EN to add a read timeout of TIMEOUT wait cycles.
module gpio_bus_arb #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_wr_valid,
   input  logic        m0_rd_valid,
   input  logic [31:0] m0_wr_addr,
   input  logic [31:0] m0_wr_data,
   input  logic [31:0] m0_rd_addr,
   output logic        m0_grant,
   output logic        m0_rd_ready,
   output logic [31:0] m0_rd_data,
   output logic        m0_rd_err,
   input  logic        m1_wr_valid,
   input  logic        m1_rd_valid,
   input  logic [31:0] m1_wr_addr,
   input  logic [31:0] m1_wr_data,
   input  logic [31:0] m1_rd_addr,
   output logic        m1_grant,
   output logic        m1_rd_ready,
   output logic [31:0] m1_rd_data,
   output logic        m1_rd_err,
   output logic        ic0_c_axi_mst_wr_valid,
   output logic        ic0_c_axi_mst_rd_valid,
   output logic [31:0] ic0_axi_mst_wr_addr,
   output logic [31:0] ic0_axi_mst_wr_data,
   output logic [31:0] ic0_axi_mst_rd_addr,
   input  logic        ic0_c_axi_slv_rd_ready,
   input  logic [31:0] ic0_axi_slv_rd_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        is_wr_q, is_wr_d;
   logic        wr_valid_q, wr_valid_d;
   logic        rd_valid_q, rd_valid_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  rd_ready_q, rd_ready_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        req0, req1, win1, sel_wr;

`ifdef GPIO_BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  rd_err_q, rd_err_d;
`endif

   // last_q holds the last granted requester; a contested request goes to the other one.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      is_wr_d    = is_wr_q;
      wr_valid_d = 1'b0;
      rd_valid_d = 1'b0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      rd_addr_d  = '0;
      grant_d    = 2'b00;
      rd_ready_d = 2'b00;
      rd_data_d  = '0;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      rd_err_d   = 2'b00;
`endif
      req0   = m0_wr_valid | m0_rd_valid;
      req1   = m1_wr_valid | m1_rd_valid;
      win1   = req1 & (~req0 | ~last_q);
      sel_wr = win1 ? m1_wr_valid : m0_wr_valid;

      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d    = ISSUE;
               owner_d    = win1;
               is_wr_d    = sel_wr;
               grant_d    = win1 ? 2'b10 : 2'b01;
               wr_valid_d = sel_wr;
               rd_valid_d = ~sel_wr;
               if (sel_wr) begin
                  wr_addr_d = win1 ? m1_wr_addr : m0_wr_addr;
                  wr_data_d = win1 ? m1_wr_data : m0_wr_data;
               end else begin
                  rd_addr_d = win1 ? m1_rd_addr : m0_rd_addr;
               end
            end
         end
         ISSUE: begin
            last_d  = owner_q;
            state_d = is_wr_q ? IDLE : RD_WAIT;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         RD_WAIT: begin
            if (ic0_c_axi_slv_rd_ready) begin
               state_d    = RESP;
               rd_ready_d = owner_q ? 2'b10 : 2'b01;
               rd_data_d  = ic0_axi_slv_rd_data;
            end
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TIMEOUT_CNT) begin
                  state_d    = RESP;
                  rd_ready_d = owner_q ? 2'b10 : 2'b01;
                  rd_err_d   = owner_q ? 2'b10 : 2'b01;
               end
            end
`endif
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         is_wr_q    <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_addr_q  <= '0;
         grant_q    <= 2'b00;
         rd_ready_q <= 2'b00;
         rd_data_q  <= '0;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         rd_err_q   <= 2'b00;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         is_wr_q    <= is_wr_d;
         wr_valid_q <= wr_valid_d;
         rd_valid_q <= rd_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_addr_q  <= rd_addr_d;
         grant_q    <= grant_d;
         rd_ready_q <= rd_ready_d;
         rd_data_q  <= rd_data_d;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rd_err_q   <= rd_err_d;
`endif
      end
   end

   assign ic0_c_axi_mst_wr_valid = wr_valid_q;
   assign ic0_c_axi_mst_rd_valid = rd_valid_q;
   assign ic0_axi_mst_wr_addr    = wr_addr_q;
   assign ic0_axi_mst_wr_data    = wr_data_q;
   assign ic0_axi_mst_rd_addr    = rd_addr_q;
   assign m0_grant               = grant_q[0];
   assign m1_grant               = grant_q[1];
   assign m0_rd_ready            = rd_ready_q[0];
   assign m1_rd_ready            = rd_ready_q[1];
   assign m0_rd_data             = rd_ready_q[0] ? rd_data_q : '0;
   assign m1_rd_data             = rd_ready_q[1] ? rd_data_q : '0;

`ifdef GPIO_BUS_ARB_TIMEOUT_EN
   assign m0_rd_err = rd_err_q[0];
   assign m1_rd_err = rd_err_q[1];
`else
   assign m0_rd_err = 1'b0;
   assign m1_rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed self-checking bench for gpio_bus_arb: writes, round-robin, reads,
// priority, read timeout (or indefinite wait) and reset during a read.
module tb_gpio_bus_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_wr_valid, m0_rd_valid, m1_wr_valid, m1_rd_valid;
   logic [31:0] m0_wr_addr, m0_wr_data, m0_rd_addr;
   logic [31:0] m1_wr_addr, m1_wr_data, m1_rd_addr;
   logic        m0_grant, m0_rd_ready, m0_rd_err;
   logic        m1_grant, m1_rd_ready, m1_rd_err;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        mst_wr_valid, mst_rd_valid;
   logic [31:0] mst_wr_addr, mst_wr_data, mst_rd_addr;
   logic        slv_rd_ready;
   logic [31:0] slv_rd_data;
   logic [167:0] all_out;

   int checks = 0;
   int failures = 0;

   gpio_bus_arb #(.TIMEOUT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_wr_valid(m0_wr_valid), .m0_rd_valid(m0_rd_valid),
      .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data), .m0_rd_addr(m0_rd_addr),
      .m0_grant(m0_grant), .m0_rd_ready(m0_rd_ready), .m0_rd_data(m0_rd_data), .m0_rd_err(m0_rd_err),
      .m1_wr_valid(m1_wr_valid), .m1_rd_valid(m1_rd_valid),
      .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data), .m1_rd_addr(m1_rd_addr),
      .m1_grant(m1_grant), .m1_rd_ready(m1_rd_ready), .m1_rd_data(m1_rd_data), .m1_rd_err(m1_rd_err),
      .ic0_c_axi_mst_wr_valid(mst_wr_valid), .ic0_c_axi_mst_rd_valid(mst_rd_valid),
      .ic0_axi_mst_wr_addr(mst_wr_addr), .ic0_axi_mst_wr_data(mst_wr_data),
      .ic0_axi_mst_rd_addr(mst_rd_addr),
      .ic0_c_axi_slv_rd_ready(slv_rd_ready), .ic0_axi_slv_rd_data(slv_rd_data)
   );

   always #5 clk = ~clk;

   assign all_out = {m0_grant, m0_rd_ready, m0_rd_data, m0_rd_err,
                     m1_grant, m1_rd_ready, m1_rd_data, m1_rd_err,
                     mst_wr_valid, mst_rd_valid, mst_wr_addr, mst_wr_data, mst_rd_addr};

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [167:0] obs, input logic [167:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic w0, input logic r0, input logic w1, input logic r1);
      m0_wr_valid = w0;
      m0_rd_valid = r0;
      m1_wr_valid = w1;
      m1_rd_valid = r1;
   endtask

   // Advance until some grant pulse is visible, bounded to 8 cycles.
   task automatic waitGrant(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         got = m0_grant | m1_grant;
      end
      checkOutput({tag, "_grant_seen"}, {167'd0, got}, 168'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0);
      m0_wr_addr = 32'h0; m0_wr_data = 32'h0; m0_rd_addr = 32'h0;
      m1_wr_addr = 32'h0; m1_wr_data = 32'h0; m1_rd_addr = 32'h0;
      slv_rd_ready = 1'b0;
      slv_rd_data  = 32'h0;
      tick();
      tick();
      checkOutput("reset_outputs", all_out, 168'd0);
      rst_n = 1'b1;
      tick();

      // Single m0 write: strobe and grant in the cycle after the request is sampled.
      m0_wr_addr = 32'h454;
      m0_wr_data = 32'h5;
      applyStimulus(1, 0, 0, 0);
      checkOutput("wr_not_early", {167'd0, mst_wr_valid}, 168'd0);
      tick();
      checkOutput("wr1_valid", {167'd0, mst_wr_valid}, 168'd1);
      checkOutput("wr1_addr", {136'd0, mst_wr_addr}, {136'd0, 32'h454});
      checkOutput("wr1_data", {136'd0, mst_wr_data}, {136'd0, 32'h5});
      checkOutput("wr1_grants", {166'd0, m1_grant, m0_grant}, 168'd1);
      checkOutput("wr1_rd_valid", {167'd0, mst_rd_valid}, 168'd0);
      applyStimulus(0, 0, 0, 0);
      tick();
      checkOutput("wr1_pulse_end", all_out, 168'd0);

      // Fresh reset so the pointer favours m0, then both writes held for four grants.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m0_wr_addr = 32'h100; m0_wr_data = 32'hA0;
      m1_wr_addr = 32'h200; m1_wr_data = 32'hB1;
      applyStimulus(1, 0, 1, 0);
      for (int g = 0; g < 4; g++) begin
         waitGrant($sformatf("rr%0d", g));
         checkOutput($sformatf("rr%0d_who", g), {166'd0, m1_grant, m0_grant},
                     (g % 2 == 0) ? 168'd1 : 168'd2);
         checkOutput($sformatf("rr%0d_addr", g), {136'd0, mst_wr_addr},
                     (g % 2 == 0) ? {136'd0, 32'h100} : {136'd0, 32'h200});
      end
      applyStimulus(0, 0, 0, 0);
      tick();
      tick();

      // m1 read; a ready during ISSUE must be ignored, the RD_WAIT one is taken.
      m1_rd_addr = 32'h460;
      applyStimulus(0, 0, 0, 1);
      waitGrant("rd1");
      checkOutput("rd1_grant", {166'd0, m1_grant, m0_grant}, 168'd2);
      checkOutput("rd1_valid", {166'd0, mst_rd_valid, mst_wr_valid}, 168'd2);
      checkOutput("rd1_addr", {136'd0, mst_rd_addr}, {136'd0, 32'h460});
      applyStimulus(0, 0, 0, 0);
      slv_rd_ready = 1'b1;
      slv_rd_data  = 32'hBAD;
      tick();
      slv_rd_data  = 32'hA;
      tick();
      slv_rd_ready = 1'b0;
      slv_rd_data  = 32'h0;
      checkOutput("rd1_ready", {166'd0, m1_rd_ready, m0_rd_ready}, 168'd2);
      checkOutput("rd1_data", {136'd0, m1_rd_data}, {136'd0, 32'hA});
      checkOutput("rd1_err", {166'd0, m1_rd_err, m0_rd_err}, 168'd0);
      checkOutput("rd1_m0_data", {136'd0, m0_rd_data}, 168'd0);
      tick();
      checkOutput("rd1_pulse_end", all_out, 168'd0);

      // m0 write+read held with m1 write: m0 wr, m1 wr, m0 rd (pointer last = m1).
      m0_wr_addr = 32'h300; m0_wr_data = 32'h33; m0_rd_addr = 32'h304;
      m1_wr_addr = 32'h400; m1_wr_data = 32'h44;
      applyStimulus(1, 1, 1, 0);
      waitGrant("pri0");
      checkOutput("pri0_grant", {166'd0, m1_grant, m0_grant}, 168'd1);
      checkOutput("pri0_valid", {166'd0, mst_rd_valid, mst_wr_valid}, 168'd1);
      checkOutput("pri0_addr", {136'd0, mst_wr_addr}, {136'd0, 32'h300});
      applyStimulus(0, 1, 1, 0);
      waitGrant("pri1");
      checkOutput("pri1_grant", {166'd0, m1_grant, m0_grant}, 168'd2);
      checkOutput("pri1_valid", {166'd0, mst_rd_valid, mst_wr_valid}, 168'd1);
      checkOutput("pri1_data", {136'd0, mst_wr_data}, {136'd0, 32'h44});
      applyStimulus(0, 1, 0, 0);
      waitGrant("pri2");
      checkOutput("pri2_grant", {166'd0, m1_grant, m0_grant}, 168'd1);
      checkOutput("pri2_valid", {166'd0, mst_rd_valid, mst_wr_valid}, 168'd2);
      checkOutput("pri2_addr", {136'd0, mst_rd_addr}, {136'd0, 32'h304});
      applyStimulus(0, 0, 0, 0);
      tick();
      slv_rd_ready = 1'b1;
      slv_rd_data  = 32'h77;
      tick();
      slv_rd_ready = 1'b0;
      checkOutput("pri2_ready", {166'd0, m1_rd_ready, m0_rd_ready}, 168'd1);
      checkOutput("pri2_data", {136'd0, m0_rd_data}, {136'd0, 32'h77});
      tick();

      // Read left unanswered.
      m0_rd_addr = 32'h500;
      applyStimulus(0, 1, 0, 0);
      waitGrant("to");
      applyStimulus(0, 0, 0, 0);
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("to_wait%0d", c), {166'd0, m0_rd_ready, m0_rd_err}, 168'd0);
      end
      tick();
      checkOutput("to_ready_err", {166'd0, m0_rd_ready, m0_rd_err}, 168'd3);
      checkOutput("to_data", {136'd0, m0_rd_data}, 168'd0);
      tick();
      checkOutput("to_pulse_end", all_out, 168'd0);
`else
      for (int c = 0; c < 20; c++) begin
         tick();
         checkOutput($sformatf("to_wait%0d", c), {166'd0, m0_rd_ready, m0_rd_err}, 168'd0);
      end
      slv_rd_ready = 1'b1;
      slv_rd_data  = 32'h33;
      tick();
      slv_rd_ready = 1'b0;
      checkOutput("to_late_ready", {166'd0, m0_rd_ready, m0_rd_err}, 168'd2);
      checkOutput("to_late_data", {136'd0, m0_rd_data}, {136'd0, 32'h33});
      tick();
`endif

      // Reset during RD_WAIT, then a stale ready after release must not produce a response.
      m1_rd_addr = 32'h600;
      applyStimulus(0, 0, 0, 1);
      waitGrant("rst");
      applyStimulus(0, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      slv_rd_ready = 1'b1;
      slv_rd_data  = 32'hEE;
      checkOutput("rst_outputs", all_out, 168'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("rst_stale%0d", c), all_out, 168'd0);
      end
      slv_rd_ready = 1'b0;
      m0_wr_addr = 32'h700;
      m0_wr_data = 32'h7;
      applyStimulus(1, 0, 0, 0);
      tick();
      checkOutput("rst_new_wr", {165'd0, m0_grant, m1_grant, mst_wr_valid}, 168'd5);
      checkOutput("rst_new_addr", {136'd0, mst_wr_addr}, {136'd0, 32'h700});
      applyStimulus(0, 0, 0, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
